// File: rtl/fifo_pkg.sv
// fifo_pkg: helpers shared by the FIFO family.
//   fifo_cnt_t  - wide occupancy/skip type; callers size-cast to their own width.
//   skip_clamp  - number of entries a skipping read consumes.
package fifo_pkg;

  localparam int unsigned FIFO_CNT_MAX_W = 16;

  typedef logic [FIFO_CNT_MAX_W-1:0] fifo_cnt_t;

  // A skip of 0 means 1. The result never exceeds the current occupancy.
  function automatic fifo_cnt_t skip_clamp(input fifo_cnt_t skip, input fifo_cnt_t usedw);
    fifo_cnt_t n;
    n = (skip == '0) ? fifo_cnt_t'(1) : skip;
    if (n > usedw) n = usedw;
    return n;
  endfunction

endpackage

// File: rtl/skip_fifo_ram.sv
// skip_fifo_ram: simple dual-port memory with a synchronous write port.
// The read port is combinational when REG_RD=0. It is registered when
// REG_RD=1: the output loads on re_i and otherwise holds its value.
// A read of an address in the cycle it is written returns the old data.
//   clk_i, rst_i            clock; async active-high reset (output register only)
//   we_i, waddr_i, wdata_i  write port
//   re_i, raddr_i           read port
//   rdata_o                 read data
module skip_fifo_ram #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned AWIDTH = 4,
  parameter int unsigned REG_RD = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [AWIDTH-1:0] waddr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AWIDTH-1:0] raddr_i,
  output logic [DWIDTH-1:0] rdata_o
);

  logic [DWIDTH-1:0] mem_q [2**AWIDTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  if (REG_RD != 0) begin : g_reg
    logic [DWIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)     rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
  end else begin : g_comb
    logic unused_ok;

    assign rdata_o   = mem_q[raddr_i];
    assign unused_ok = &{1'b0, re_i, rst_i};
  end

endmodule

// File: rtl/skip_fifo.sv
// skip_fifo: single-clock FIFO whose reads consume 1..DEPTH entries.
// An accepted read returns the head word and discards the following
// skip-1 entries.
//   clk_i, arst_i     clock; async active-high reset
//   flush_i           synchronous clear; overrides rd/wr with no error pulses
//   wr_i, wrdata_i    write request and data
//   rd_i, skip_i      read request; entries consumed (0 means 1, clamped to usedw)
//   rddata_o          head word (SHOWAHEAD=1) or registered read data (SHOWAHEAD=0)
//   rdvalid_o         read data valid pulse (SHOWAHEAD=0 only, else 0)
//   usedw_o           occupancy 0..DEPTH
//   empty_o, full_o, almost_empty_o, almost_full_o   registered status flags
//   overflow_o, underflow_o                          one-cycle error pulses
module skip_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DWIDTH       = 8,
  parameter int unsigned AWIDTH       = 4,
  parameter int unsigned ALMOST_FULL  = 12,
  parameter int unsigned ALMOST_EMPTY = 2,
  parameter int unsigned SHOWAHEAD    = 1
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              flush_i,
  input  logic              wr_i,
  input  logic [DWIDTH-1:0] wrdata_i,
  input  logic              rd_i,
  input  logic [AWIDTH:0]   skip_i,
  output logic [DWIDTH-1:0] rddata_o,
  output logic              rdvalid_o,
  output logic [AWIDTH:0]   usedw_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              almost_empty_o,
  output logic              almost_full_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  typedef logic [AWIDTH:0]   cnt_t;
  typedef logic [AWIDTH-1:0] ptr_t;

  localparam cnt_t DEPTH_C = cnt_t'(2**AWIDTH);
  localparam cnt_t AF_C    = cnt_t'(ALMOST_FULL);
  localparam cnt_t AE_C    = cnt_t'(ALMOST_EMPTY);

  ptr_t wrptr_q, wrptr_d;
  ptr_t rdptr_q, rdptr_d;
  cnt_t usedw_q, usedw_d;
  logic empty_q, empty_d;
  logic full_q, full_d;
  logic aempty_q, aempty_d;
  logic afull_q, afull_d;
  logic rdvalid_q, rdvalid_d;
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  logic rd_acc;
  logic wr_acc;
  cnt_t n;

  always_comb begin
    n       = cnt_t'(skip_clamp(fifo_cnt_t'(skip_i), fifo_cnt_t'(usedw_q)));
    rd_acc  = 1'b0;
    wr_acc  = 1'b0;
    wrptr_d = wrptr_q;
    rdptr_d = rdptr_q;
    usedw_d = usedw_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;

    if (flush_i) begin
      wrptr_d = '0;
      rdptr_d = '0;
      usedw_d = '0;
    end else begin
      rd_acc = rd_i && (usedw_q != '0);
      // A read in the same cycle frees a slot, so a full FIFO still takes the write.
      wr_acc = wr_i && ((usedw_q != DEPTH_C) || rd_acc);
      ovf_d  = wr_i && !wr_acc;
      unf_d  = rd_i && !rd_acc;

      if (rd_acc) begin
        // n may equal DEPTH; the modulo-DEPTH pointer then lands back on itself.
        rdptr_d = rdptr_q + n[AWIDTH-1:0];
        usedw_d = usedw_d - n;
      end
      if (wr_acc) begin
        wrptr_d = wrptr_q + ptr_t'(1);
        usedw_d = usedw_d + cnt_t'(1);
      end
    end

    empty_d   = (usedw_d == '0);
    full_d    = (usedw_d == DEPTH_C);
    afull_d   = (usedw_d >= AF_C);
    aempty_d  = (usedw_d <= AE_C);
    rdvalid_d = (SHOWAHEAD == 0) && rd_acc;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wrptr_q   <= '0;
      rdptr_q   <= '0;
      usedw_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      aempty_q  <= 1'b1;
      afull_q   <= 1'b0;
      rdvalid_q <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      wrptr_q   <= wrptr_d;
      rdptr_q   <= rdptr_d;
      usedw_q   <= usedw_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      aempty_q  <= aempty_d;
      afull_q   <= afull_d;
      rdvalid_q <= rdvalid_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  skip_fifo_ram #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH),
    .REG_RD ((SHOWAHEAD == 0) ? 1 : 0)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_i   (arst_i),
    .we_i    (wr_acc),
    .waddr_i (wrptr_q),
    .wdata_i (wrdata_i),
    .re_i    (rd_acc),
    .raddr_i (rdptr_q),
    .rdata_o (rddata_o)
  );

  assign rdvalid_o      = rdvalid_q;
  assign usedw_o        = usedw_q;
  assign empty_o        = empty_q;
  assign full_o         = full_q;
  assign almost_empty_o = aempty_q;
  assign almost_full_o  = afull_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;

endmodule

// File: tb/tb_skip_fifo.sv
// Bench for skip_fifo: a show-ahead and a registered-read instance share the
// same stimulus and are both compared against a queue model every cycle.
module tb_skip_fifo;

  logic       clk_i    = 1'b0;
  logic       arst_i   = 1'b1;
  logic       flush_i  = 1'b0;
  logic       wr_i     = 1'b0;
  logic [7:0] wrdata_i = '0;
  logic       rd_i     = 1'b0;
  logic [4:0] skip_i   = '0;

  logic [7:0] sa_rddata, rg_rddata;
  logic       sa_rdvalid, rg_rdvalid;
  logic [4:0] sa_usedw, rg_usedw;
  logic       sa_empty, rg_empty, sa_full, rg_full;
  logic       sa_ae, rg_ae, sa_af, rg_af;
  logic       sa_ovf, rg_ovf, sa_unf, rg_unf;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  skip_fifo #(
    .DWIDTH (8), .AWIDTH (4), .ALMOST_FULL (12), .ALMOST_EMPTY (2), .SHOWAHEAD (1)
  ) dut_sa (
    .clk_i (clk_i), .arst_i (arst_i), .flush_i (flush_i),
    .wr_i (wr_i), .wrdata_i (wrdata_i), .rd_i (rd_i), .skip_i (skip_i),
    .rddata_o (sa_rddata), .rdvalid_o (sa_rdvalid), .usedw_o (sa_usedw),
    .empty_o (sa_empty), .full_o (sa_full), .almost_empty_o (sa_ae),
    .almost_full_o (sa_af), .overflow_o (sa_ovf), .underflow_o (sa_unf)
  );

  skip_fifo #(
    .DWIDTH (8), .AWIDTH (4), .ALMOST_FULL (12), .ALMOST_EMPTY (2), .SHOWAHEAD (0)
  ) dut_rg (
    .clk_i (clk_i), .arst_i (arst_i), .flush_i (flush_i),
    .wr_i (wr_i), .wrdata_i (wrdata_i), .rd_i (rd_i), .skip_i (skip_i),
    .rddata_o (rg_rddata), .rdvalid_o (rg_rdvalid), .usedw_o (rg_usedw),
    .empty_o (rg_empty), .full_o (rg_full), .almost_empty_o (rg_ae),
    .almost_full_o (rg_af), .overflow_o (rg_ovf), .underflow_o (rg_unf)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] mq[$];
  logic [7:0] m_rdreg = '0;
  logic       m_rv    = 1'b0;
  logic       m_ovf   = 1'b0;
  logic       m_unf   = 1'b0;

  always @(posedge clk_i or posedge arst_i) begin : model
    int  sz;
    int  n;
    bit  ra;
    bit  wa;
    if (arst_i) begin
      mq.delete();
      m_rdreg = '0;
      m_rv = 0; m_ovf = 0; m_unf = 0;
    end else if (flush_i) begin
      mq.delete();
      m_rv = 0; m_ovf = 0; m_unf = 0;
    end else begin
      sz = mq.size();
      ra = rd_i && (sz > 0);
      wa = wr_i && ((sz < 16) || ra);
      n  = (skip_i == 0) ? 1 : int'(skip_i);
      if (n > sz) n = sz;
      m_ovf = wr_i && !wa;
      m_unf = rd_i && !ra;
      m_rv  = ra;
      if (ra) begin
        m_rdreg = mq[0];
        for (int k = 0; k < n; k++) void'(mq.pop_front());
      end
      if (wa) mq.push_back(wrdata_i);
    end
    #1;
    sz = mq.size();
    chk("sa_usedw", sa_usedw, sz);
    chk("rg_usedw", rg_usedw, sz);
    chk("sa_empty", sa_empty, sz == 0);
    chk("rg_empty", rg_empty, sz == 0);
    chk("sa_full", sa_full, sz == 16);
    chk("rg_full", rg_full, sz == 16);
    chk("sa_afull", sa_af, sz >= 12);
    chk("rg_afull", rg_af, sz >= 12);
    chk("sa_aempty", sa_ae, sz <= 2);
    chk("rg_aempty", rg_ae, sz <= 2);
    chk("sa_ovf", sa_ovf, m_ovf);
    chk("rg_ovf", rg_ovf, m_ovf);
    chk("sa_unf", sa_unf, m_unf);
    chk("rg_unf", rg_unf, m_unf);
    chk("sa_rdvalid", sa_rdvalid, 1'b0);
    chk("rg_rdvalid", rg_rdvalid, m_rv);
    chk("rg_rddata", rg_rddata, m_rdreg);
    if (sz > 0) chk("sa_head", sa_rddata, mq[0]);
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input logic w, input logic [7:0] d, input logic r,
                      input logic [4:0] s, input logic f);
    wr_i = w; wrdata_i = d; rd_i = r; skip_i = s; flush_i = f;
    @(negedge clk_i);
    wr_i = 0; rd_i = 0; flush_i = 0; skip_i = '0;
  endtask

  initial begin
    int wc;
    bit w;

    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_usedw", sa_usedw, 0);
    chk("rst_empty", rg_empty, 1);
    chk("rst_aempty", sa_ae, 1);
    chk("rst_full", sa_full, 0);
    chk("rst_afull", rg_af, 0);
    chk("rst_rdvalid", rg_rdvalid, 0);
    chk("rst_rg_rddata", rg_rddata, 8'h00);
    arst_i = 0;
    @(negedge clk_i);

    // Fill with 0x00..0x0F, then overflow
    for (int i = 0; i < 16; i++) begin
      step(1, 8'(i), 0, 0, 0);
      if (i == 1)  chk("fill_ae_at2", sa_ae, 1);
      if (i == 2)  chk("fill_ae_at3", sa_ae, 0);
      if (i == 10) chk("fill_af_at11", sa_af, 0);
      if (i == 11) chk("fill_af_at12", sa_af, 1);
    end
    chk("fill_full", sa_full, 1);
    chk("fill_usedw", rg_usedw, 16);
    step(1, 8'h77, 0, 0, 0);
    chk("fill_ovf", sa_ovf, 1);
    chk("fill_ovf_usedw", sa_usedw, 16);
    step(0, 0, 0, 0, 0);
    chk("fill_ovf_pulse_end", sa_ovf, 0);

    // Full with rd+wr: both accepted
    step(1, 8'hAA, 1, 1, 0);
    chk("fullrw_usedw", sa_usedw, 16);
    chk("fullrw_full", rg_full, 1);
    chk("fullrw_ovf", sa_ovf, 0);
    chk("fullrw_rg_data", rg_rddata, 8'h00);
    for (int k = 0; k < 16; k++) begin
      step(0, 0, 1, 1, 0);
      chk("drain_rg_data", rg_rddata, (k < 15) ? 32'(k + 1) : 32'hAA);
    end
    chk("drain_empty", sa_empty, 1);

    // Skip of 3 over 0x00..0x09
    for (int i = 0; i < 10; i++) step(1, 8'(i), 0, 0, 0);
    step(0, 0, 1, 3, 0);
    chk("skip_rg_data", rg_rddata, 8'h00);
    chk("skip_rg_valid", rg_rdvalid, 1);
    chk("skip_sa_head", sa_rddata, 8'h03);
    chk("skip_usedw", sa_usedw, 7);
    step(0, 0, 0, 0, 0);
    chk("skip_valid_1cyc", rg_rdvalid, 0);

    // Clamp: 5 of 7, then 5 of 2, then underflow
    step(0, 0, 1, 5, 0);
    chk("clamp_usedw2", sa_usedw, 2);
    chk("clamp_rg_data", rg_rddata, 8'h03);
    step(0, 0, 1, 5, 0);
    chk("clamp_usedw0", sa_usedw, 0);
    chk("clamp_empty", sa_empty, 1);
    chk("clamp_aempty", rg_ae, 1);
    chk("clamp_rg_data2", rg_rddata, 8'h08);
    step(0, 0, 1, 1, 0);
    chk("clamp_unf", sa_unf, 1);

    // Empty with rd+wr: only the write lands
    step(1, 8'h55, 1, 1, 0);
    chk("emptyrw_unf", rg_unf, 1);
    chk("emptyrw_usedw", sa_usedw, 1);
    chk("emptyrw_empty", sa_empty, 0);
    chk("emptyrw_head", sa_rddata, 8'h55);
    chk("emptyrw_rg_valid", rg_rdvalid, 0);
    step(0, 0, 1, 0, 0);
    chk("skip0_rg_data", rg_rddata, 8'h55);
    chk("skip0_empty", sa_empty, 1);

    // 40 words across pointer wrap with interleaved rd/wr
    wc = 0;
    for (int i = 0; i < 70; i++) begin
      w = (wc < 40) && (i % 3 != 2);
      step(w, 8'(8'h80 + wc), (i % 2 == 1), ((i % 4) == 3) ? 5'd0 : 5'd1, 0);
      if (w) wc++;
    end
    repeat (20) step(0, 0, 1, 1, 0);
    chk("wrap_empty", rg_empty, 1);

    // Asynchronous reset mid-stream
    step(1, 8'h31, 0, 0, 0);
    step(1, 8'h32, 0, 0, 0);
    step(1, 8'h33, 1, 1, 0);
    chk("pre_rst_rg_data", rg_rddata, 8'h31);
    wr_i = 1; wrdata_i = 8'h34;
    #3 arst_i = 1;
    #1;
    chk("arst_usedw", sa_usedw, 0);
    chk("arst_empty", rg_empty, 1);
    chk("arst_rg_data", rg_rddata, 8'h00);
    @(negedge clk_i);
    arst_i = 0; wr_i = 0;
    step(1, 8'hC1, 0, 0, 0);
    chk("post_rst_head", sa_rddata, 8'hC1);
    chk("post_rst_usedw", sa_usedw, 1);

    // Flush with write, and flush on a full FIFO with rd+wr
    step(1, 8'hC2, 0, 0, 0);
    step(1, 8'h99, 0, 0, 1);
    chk("flush_usedw", sa_usedw, 0);
    chk("flush_ovf", sa_ovf, 0);
    chk("flush_empty", rg_empty, 1);
    for (int i = 0; i < 16; i++) step(1, 8'(8'hE0 + i), 0, 0, 0);
    step(1, 8'h11, 1, 1, 1);
    chk("flushfull_usedw", rg_usedw, 0);
    chk("flushfull_ovf", rg_ovf, 0);
    chk("flushfull_unf", sa_unf, 0);
    chk("flushfull_rdvalid", rg_rdvalid, 0);
    step(1, 8'h5A, 0, 0, 0);
    chk("flush_first_head", sa_rddata, 8'h5A);
    step(0, 0, 1, 1, 0);
    chk("flush_first_rg", rg_rddata, 8'h5A);
    step(0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
